// File: rtl/pattern_frame_ctrl.sv
// Framed, non-overlapping 4-bit serial pattern search with a match count.
// A host start latches pattern and frame length; exactly frame_len bits are consumed.
module pattern_frame_ctrl #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       pattern,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic             ser_ready,
    output logic             busy,
    output logic             found,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_t;

    state_t           state;
    logic [3:0]       pat_q;
    logic [3:0]       window;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    logic [2:0]       fresh;

    logic             accept;
    logic [3:0]       win_nxt;
    logic [2:0]       fresh_nxt;
    logic             hit;

    function automatic logic [2:0] sat_fresh(input logic [2:0] f);
        return (f >= 3'd4) ? 3'd4 : f + 3'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign ser_ready = (state == SCAN);
    assign busy      = (state != IDLE);
    assign accept    = ser_valid && ser_ready;
    assign win_nxt   = {window[2:0], ser_in};
    assign fresh_nxt = sat_fresh(fresh);
    // Only a full set of post-match bits may form a hit, so prefill never matches.
    assign hit       = (win_nxt == pat_q) && (fresh_nxt == 3'd4);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            window      <= '0;
            remaining   <= '0;
            fresh       <= '0;
            found       <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            found <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        len_q       <= frame_len;
                        match_count <= '0;
                        overflow    <= 1'b0;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    window    <= {4{~pat_q[0]}};
                    fresh     <= '0;
                    remaining <= len_q;
                    if (len_q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        window    <= win_nxt;
                        remaining <= remaining - LEN_W'(1);
                        if (hit) begin
                            found       <= 1'b1;
                            fresh       <= '0;
                            match_count <= sat_count(match_count);
                            if (&match_count)
                                overflow <= 1'b1;
                        end else begin
                            fresh <= fresh_nxt;
                        end
                        if (remaining == LEN_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
